seq10_frame_ctrl: RTL and testbench

- Frame-level controller for the serial "10" sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an embedded detector, one bit per clock.
- Counts detector matches over a programmable frame of N words, then reports the count with a one-cycle done pulse.
- Sits between a word-wide producer and the bit-serial detection datapath; the only sequencer of that datapath.

---
 rtl/seq10_pkg.sv | 15 +
 rtl/seq10_det.sv | 26 ++
 rtl/seq10_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_seq10_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq10_pkg.sv
// rtl/seq10_pkg.sv - shared state encoding and default widths for the seq10 frame controller
package seq10_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_FRAME_W = 4;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq10_det.sv
// rtl/seq10_det.sv - bit-serial "10" detector with one history flop
module seq10_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic match_o
);

    logic hist;

    // Mealy output: a 1 seen last time followed by a 0 now.
    assign match_o = en_i && hist && !bit_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hist <= 1'b0;
        end else if (clr_i) begin
            hist <= 1'b0;
        end else if (en_i) begin
            hist <= bit_i;
        end
    end

endmodule

// File: rtl/seq10_frame_ctrl.sv
// rtl/seq10_frame_ctrl.sv - word-to-bit frame sequencer counting "10" matches per frame
module seq10_frame_ctrl
    import seq10_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_len_i,
    input  logic               word_valid_i,
    input  logic [DATA_W-1:0]  word_data_i,
    output logic               word_ready_o,
    output logic               busy_o,
    output logic               match_pulse_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               overflow_o
);

    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] words_rem;
    logic [DATA_W-1:0]  shift_reg;
    logic [BIT_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   match_cnt;
    logic               overflow;
    logic               start_acc;
    logic               word_acc;
    logic               det_en;
    logic               det_match;

    assign start_acc = (state == ST_IDLE) && start_i;
    assign word_acc  = (state == ST_LOAD) && word_valid_i;
    assign det_en    = (state == ST_SHIFT);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_ready_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = (frame_len_i == '0) ? ST_REPORT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_idx == '0) begin
                    state_nxt = (words_rem != '0) ? ST_LOAD : ST_REPORT;
                end
            end
            ST_REPORT: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            words_rem <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start_acc) begin
                words_rem <= frame_len_i;
                match_cnt <= '0;
                overflow  <= 1'b0;
            end
            // LOAD is only entered with words remaining, so the decrement never wraps.
            if (word_acc) begin
                shift_reg <= word_data_i;
                words_rem <= words_rem - 1'b1;
                bit_idx   <= LAST_BIT;
            end else if (det_en) begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                bit_idx   <= bit_idx - 1'b1;
            end
            if (det_match) begin
                if (match_cnt == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

    seq10_det u_det (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (start_acc),
        .en_i    (det_en),
        .bit_i   (shift_reg[DATA_W-1]),
        .match_o (det_match)
    );

    assign match_pulse_o = det_match;
    assign match_cnt_o   = match_cnt;
    assign overflow_o    = overflow;

endmodule

// File: tb/tb_seq10_frame_ctrl.sv
// tb/tb_seq10_frame_ctrl.sv - table-driven and randomized bench for seq10_frame_ctrl
module tb_seq10_frame_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [3:0] frame_len_i;
    logic       word_valid_i;
    logic [7:0] word_data_i;

    logic       word_ready, busy, match_pulse, done, overflow;
    logic [7:0] match_cnt;
    logic       word_ready4, busy4, match_pulse4, done4, overflow4;
    logic [3:0] match_cnt4;

    int checks = 0;
    int errors = 0;

    logic [7:0] fw [16];

    always #5 clk_i = ~clk_i;

    seq10_frame_ctrl dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .frame_len_i   (frame_len_i),
        .word_valid_i  (word_valid_i),
        .word_data_i   (word_data_i),
        .word_ready_o  (word_ready),
        .busy_o        (busy),
        .match_pulse_o (match_pulse),
        .done_o        (done),
        .match_cnt_o   (match_cnt),
        .overflow_o    (overflow)
    );

    seq10_frame_ctrl #(.CNT_W(4)) dut4 (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .frame_len_i   (frame_len_i),
        .word_valid_i  (word_valid_i),
        .word_data_i   (word_data_i),
        .word_ready_o  (word_ready4),
        .busy_o        (busy4),
        .match_pulse_o (match_pulse4),
        .done_o        (done4),
        .match_cnt_o   (match_cnt4),
        .overflow_o    (overflow4)
    );

    typedef struct {
        int          len;
        logic [39:0] words;
        int          gap;
        bit          noisy;
        int          cnt8;
        bit          ovf8;
        int          cnt4;
        bit          ovf4;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference: count 1->0 transitions over the MSB-first bit stream of the frame.
    function automatic int raw_matches(input int len);
        bit bits[$];
        int n = 0;
        for (int k = 0; k < len; k++)
            for (int b = 7; b >= 0; b--)
                bits.push_back(fw[k][b]);
        for (int i = 1; i < bits.size(); i++)
            if (bits[i-1] && !bits[i]) n++;
        return n;
    endfunction

    task automatic run_frame(input int len, input int gap, input bit noisy,
                             input int cnt8, input bit ovf8, input int cnt4, input bit ovf4);
        bit bits[$];
        int idx;
        bit exp_pulse;
        for (int k = 0; k < len; k++)
            for (int b = 7; b >= 0; b--)
                bits.push_back(fw[k][b]);
        #1 chk("idle_busy", busy, 0);
        start_i     = 1'b1;
        frame_len_i = len[3:0];
        tick();
        start_i     = noisy;
        frame_len_i = noisy ? (len[3:0] ^ 4'd5) : 4'd0;
        if (len == 0) begin
            #1;
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 1);
        end else begin
            idx = 0;
            for (int k = 0; k < len; k++) begin
                for (int g = 0; g < gap; g++) begin
                    #1;
                    chk("gap_ready", word_ready, 1);
                    chk("gap_pulse", match_pulse, 0);
                    chk("gap_done", done, 0);
                    tick();
                end
                word_valid_i = 1'b1;
                word_data_i  = fw[k];
                #1 chk("load_ready", word_ready, 1);
                tick();
                word_valid_i = 1'b0;
                word_data_i  = 8'($urandom);
                for (int b = 0; b < 8; b++) begin
                    exp_pulse = (idx > 0) && bits[idx-1] && !bits[idx];
                    #1;
                    chk("pulse", match_pulse, exp_pulse);
                    chk("shift_ready", word_ready, 0);
                    chk("shift_done", done, 0);
                    idx++;
                    tick();
                end
            end
            #1 chk("report_done", done, 1);
        end
        chk("report_cnt", match_cnt, cnt8);
        chk("report_ovf", overflow, ovf8);
        chk("report_cnt4", match_cnt4, cnt4);
        chk("report_ovf4", overflow4, ovf4);
        chk("report_done4", done4, 1);
        tick();
        start_i = 1'b0;
        #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("hold_cnt", match_cnt, cnt8);
        chk("hold_ovf", overflow, ovf8);
    endtask

    initial begin
        vec_t tbl [8];
        int   raw;

        tbl[0] = '{1, 40'hA5_00_00_00_00, 0, 0, 3, 0, 3, 0};
        tbl[1] = '{2, 40'h01_00_00_00_00, 0, 0, 1, 0, 1, 0};
        tbl[2] = '{1, 40'h01_00_00_00_00, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 40'h00_00_00_00_00, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{5, 40'hAA_AA_AA_AA_AA, 0, 0, 20, 0, 15, 1};
        tbl[5] = '{0, 40'h00_00_00_00_00, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 40'h80_00_00_00_00, 5, 0, 1, 0, 1, 0};
        tbl[7] = '{2, 40'h80_80_00_00_00, 1, 1, 2, 0, 2, 0};

        reset_i      = 1'b0;
        start_i      = 1'b0;
        frame_len_i  = 4'd0;
        word_valid_i = 1'b0;
        word_data_i  = 8'd0;
        tick();
        tick();
        chk("rst_ready", word_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_pulse", match_pulse, 0);
        reset_i = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 5; k++) fw[k] = tbl[i].words[39-8*k -: 8];
            run_frame(tbl[i].len, tbl[i].gap, tbl[i].noisy,
                      tbl[i].cnt8, tbl[i].ovf8, tbl[i].cnt4, tbl[i].ovf4);
        end

        // Reset during the second word of a three-word frame abandons it.
        fw[0] = 8'hA5; fw[1] = 8'hA5; fw[2] = 8'hA5;
        start_i = 1'b1; frame_len_i = 4'd3;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            word_valid_i = 1'b1; word_data_i = fw[k];
            tick();
            word_valid_i = 1'b0;
            for (int b = 0; b < ((k == 0) ? 8 : 3); b++) tick();
        end
        #1 chk("pre_rst_cnt", match_cnt, 4);
        reset_i = 1'b0;
        #1;
        chk("mid_rst_ready", word_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cnt", match_cnt, 0);
        chk("mid_rst_ovf", overflow, 0);
        tick();
        reset_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("abandon_done", done, 0);
            chk("abandon_busy", busy, 0);
            tick();
        end

        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) fw[k] = 8'($urandom);
            raw = raw_matches(len);
            run_frame(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      (raw > 255) ? 255 : raw, raw > 255,
                      (raw > 15) ? 15 : raw, raw > 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
